// File: rtl/vec_scan_pkg.sv
// Shared types and defaults for the vector scan port.
package vec_scan_pkg;

  localparam int unsigned DEF_IN_W  = 50;
  localparam int unsigned DEF_OUT_W = 30;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT_IN,
    ST_APPLY,
    ST_CAPTURE,
    ST_SHIFT_OUT
  } state_t;

  // Minimum counter width able to hold values 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vec_shreg.sv
// Parallel-load / serial shift register, shifts toward the MSB, LSB fed by i_sin.
module vec_shreg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_shift,
  input  logic         i_sin,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;
  logic [W-1:0] w_shift;

  if (W > 1) begin : g_wide
    assign w_shift = {r_q[W-2:0], i_sin};
  end else begin : g_one
    assign w_shift = i_sin;
  end

  // Load has priority over shift; both are qualified by the caller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_load_val;
    end else if (i_shift) begin
      r_q <= w_shift;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/vec_scan_port.sv
// Serial-in / serial-out scan port: collects a stimulus vector, applies it to an
// external device, captures its response and shifts the response back out.
module vec_scan_port
  import vec_scan_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             si,
  input  logic             si_valid,
  output logic             si_ready,
  output logic [IN_W-1:0]  dut_in,
  input  logic [OUT_W-1:0] dut_out,
  output logic             so,
  output logic             so_valid,
  input  logic             so_ready,
  output logic             busy,
  output logic [15:0]      vec_count
);

  localparam int unsigned INC_W  = cnt_w(IN_W);
  localparam int unsigned SETC_W = cnt_w(SETTLE);
  localparam int unsigned OUTC_W = cnt_w(OUT_W);

  state_t              r_state, w_state_nxt;
  logic [INC_W-1:0]    r_in_cnt, w_in_cnt_nxt;
  logic [SETC_W-1:0]   r_set_cnt, w_set_cnt_nxt;
  logic [OUTC_W-1:0]   r_out_cnt, w_out_cnt_nxt;
  logic [IN_W-1:0]     r_dut_in;
  logic [15:0]         r_vec_count, w_vec_count_nxt;
  logic                w_in_beat, w_out_beat;
  logic                w_dut_in_load, w_resp_load, w_vec_inc;
  logic [IN_W-2:0]     w_stim_q;
  logic [IN_W-1:0]     w_dut_in_nxt;
  logic [OUT_W-1:0]    w_resp_q;
  logic [OUT_W-2:0]    w_resp_unused;

  // The stimulus register only holds the first IN_W-1 bits; the final bit is
  // taken straight from si so dut_in can be loaded on the completing beat.
  vec_shreg #(.W(IN_W - 1)) u_stim (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_shift    (w_in_beat),
    .i_sin      (si),
    .o_q        (w_stim_q)
  );

  vec_shreg #(.W(OUT_W)) u_resp (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_resp_load),
    .i_load_val (dut_out),
    .i_shift    (w_out_beat),
    .i_sin      (1'b0),
    .o_q        (w_resp_q)
  );

  // Lower response bits only leave the block through the shift path.
  assign w_resp_unused = w_resp_q[OUT_W-2:0];
  assign w_dut_in_nxt  = {w_stim_q, si};

  assign si_ready  = (r_state == ST_IDLE) || (r_state == ST_SHIFT_IN);
  assign busy      = (r_state != ST_IDLE);
  assign so_valid  = (r_state == ST_SHIFT_OUT);
  assign so        = so_valid & w_resp_q[OUT_W-1];
  assign w_in_beat  = si_valid & si_ready;
  assign w_out_beat = so_valid & so_ready;
  assign dut_in    = r_dut_in;
  assign vec_count = r_vec_count;

  // Next-state, counter and load-strobe decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_in_cnt_nxt  = r_in_cnt;
    w_set_cnt_nxt = r_set_cnt;
    w_out_cnt_nxt = r_out_cnt;
    w_dut_in_load = 1'b0;
    w_resp_load   = 1'b0;
    w_vec_inc     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_in_beat) begin
          w_in_cnt_nxt = INC_W'(1);
          w_state_nxt  = ST_SHIFT_IN;
        end
      end
      ST_SHIFT_IN: begin
        if (w_in_beat) begin
          if (r_in_cnt == INC_W'(IN_W - 1)) begin
            w_state_nxt   = ST_APPLY;
            w_dut_in_load = 1'b1;
            w_set_cnt_nxt = '0;
          end else begin
            w_in_cnt_nxt = r_in_cnt + INC_W'(1);
          end
        end
      end
      ST_APPLY: begin
        if (r_set_cnt == SETC_W'(SETTLE - 1)) begin
          w_state_nxt = ST_CAPTURE;
        end else begin
          w_set_cnt_nxt = r_set_cnt + SETC_W'(1);
        end
      end
      ST_CAPTURE: begin
        w_resp_load   = 1'b1;
        w_out_cnt_nxt = '0;
        w_state_nxt   = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        if (w_out_beat) begin
          if (r_out_cnt == OUTC_W'(OUT_W - 1)) begin
            w_state_nxt = ST_IDLE;
            w_vec_inc   = 1'b1;
          end else begin
            w_out_cnt_nxt = r_out_cnt + OUTC_W'(1);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_vec_count_nxt = (w_vec_inc && (r_vec_count != '1)) ? r_vec_count + 16'd1 : r_vec_count;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_in_cnt  <= '0;
      r_set_cnt <= '0;
      r_out_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_in_cnt  <= w_in_cnt_nxt;
      r_set_cnt <= w_set_cnt_nxt;
      r_out_cnt <= w_out_cnt_nxt;
    end
  end

  // Applied stimulus and completed-vector count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dut_in    <= '0;
      r_vec_count <= '0;
    end else begin
      if (w_dut_in_load) begin
        r_dut_in <= w_dut_in_nxt;
      end
      r_vec_count <= w_vec_count_nxt;
    end
  end

endmodule

// File: tb/tb_vec_scan_port.sv
// Self-checking bench for vec_scan_port with a small combinational device model.
module tb_vec_scan_port;

  localparam int unsigned IN_W   = 50;
  localparam int unsigned OUT_W  = 30;
  localparam int unsigned SETTLE = 2;
  localparam logic [29:0] K_ZERO = 30'b100101010101001011101001011000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        si, si_valid, si_ready;
  logic [49:0] dut_in;
  logic [29:0] dut_out;
  logic        so, so_valid, so_ready;
  logic        busy;
  logic [15:0] vec_count;

  int tests  = 0;
  int failed = 0;
  logic [29:0] exp_q[$];

  // Device attached to the port: constant pattern, upper stimulus bits folded
  // in, and a bit-3/bit-2 coincidence detector flipping response bits 29 and 3.
  function automatic logic [29:0] team_dut(input logic [49:0] v);
    logic a;
    a = v[3] & v[2];
    return K_ZERO ^ v[49:20] ^ {a, 25'b0, a, 3'b0};
  endfunction

  always_comb dut_out = team_dut(dut_in);

  always #5 clk = ~clk;

  vec_scan_port #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .si        (si),
    .si_valid  (si_valid),
    .si_ready  (si_ready),
    .dut_in    (dut_in),
    .dut_out   (dut_out),
    .so        (so),
    .so_valid  (so_valid),
    .so_ready  (so_ready),
    .busy      (busy),
    .vec_count (vec_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: assembles unloaded responses and compares against the scoreboard.
  initial begin
    logic [29:0] acc;
    int n;
    acc = '0;
    n   = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = 0;
      end else begin
        if (!so_valid) check("so_zero_when_invalid", so, 1'b0);
        if (so_valid && so_ready) begin
          acc = {acc[28:0], so};
          n++;
          if (n == 30) begin
            n = 0;
            if (exp_q.size() == 0) begin
              tests++;
              failed++;
              $display("FAIL response_unexpected: got %0h expected none", acc);
            end else begin
              check("response", acc, exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  // Shift a full vector in, MSB first; optional idle cycle before every beat.
  task automatic send_vec(input logic [49:0] v, input bit toggle, input logic [29:0] exp);
    exp_q.push_back(exp);
    for (int i = 49; i >= 0; i--) begin
      if (toggle) begin
        si_valid = 1'b0;
        si       = ~v[i];
        tick();
      end
      si       = v[i];
      si_valid = 1'b1;
      if (i == 0) check("ready_before_last_beat", si_ready, 1'b1);
      tick();
    end
    si_valid = 1'b0;
    si       = 1'b0;
  endtask

  // Post-shift checks: apply, latency, optional unload stall, completion.
  task automatic finish_vec(input logic [49:0] v, input int stall_at);
    int cyc;
    logic s0;
    check("dut_in_applied", dut_in, v);
    check("si_ready_low_apply", si_ready, 1'b0);
    check("busy_apply", busy, 1'b1);
    cyc = 0;
    while (!so_valid && cyc < 50) begin
      tick();
      cyc++;
      check("dut_in_stable", dut_in, v);
    end
    check("latency", cyc, SETTLE + 1);
    if (stall_at >= 0) begin
      repeat (stall_at) tick();
      so_ready = 1'b0;
      s0 = so;
      repeat (5) begin
        tick();
        check("stall_so_stable", so, s0);
        check("stall_so_valid", so_valid, 1'b1);
      end
      so_ready = 1'b1;
    end
    cyc = 0;
    while (busy && cyc < 500) begin
      tick();
      cyc++;
    end
    check("unload_done", busy, 1'b0);
    check("dut_in_hold_idle", dut_in, v);
    check("si_ready_idle", si_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [49:0] v;
    rst_n    = 1'b0;
    si       = 1'b0;
    si_valid = 1'b0;
    so_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_so_valid", so_valid, 1'b0);
    check("rst_so", so, 1'b0);
    check("rst_dut_in", dut_in, 50'h0);
    check("rst_vec_count", vec_count, 16'h0);
    check("rst_si_ready", si_ready, 1'b1);
    rst_n = 1'b1;
    tick();

    // Partial vector aborted by reset.
    v = 50'h3_FFFF_FFFF_FFFF;
    for (int i = 49; i >= 30; i--) begin
      si       = v[i];
      si_valid = 1'b1;
      tick();
    end
    si_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_busy", busy, 1'b0);
    check("midrst_so_valid", so_valid, 1'b0);
    check("midrst_so", so, 1'b0);
    check("midrst_dut_in", dut_in, 50'h0);
    check("midrst_vec_count", vec_count, 16'h0);
    check("midrst_si_ready", si_ready, 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // All-zero stimulus.
    send_vec(50'h0, 1'b0, K_ZERO);
    finish_vec(50'h0, -1);
    check("vec_count_1", vec_count, 16'd1);

    // Bits 3 and 2 set.
    send_vec(50'h0C, 1'b0, {1'b0, 25'b0010101010100101110100101, 1'b0, 3'b000});
    finish_vec(50'h0C, -1);
    check("vec_count_2", vec_count, 16'd2);

    // si_valid toggling every other cycle.
    v = 50'h3_5A5A_C3C3_F00F;
    send_vec(v, 1'b1, team_dut(v));
    finish_vec(v, -1);
    check("vec_count_3", vec_count, 16'd3);

    // so_ready stalled for 5 cycles after 10 unloaded bits.
    v = 50'h1_2345_6789_ABCD;
    send_vec(v, 1'b0, team_dut(v));
    finish_vec(v, 10);
    check("vec_count_4", vec_count, 16'd4);

    // Saturation from 16'hFFFE.
    force dut.r_vec_count = 16'hFFFE;
    tick();
    release dut.r_vec_count;
    tick();
    check("vec_count_preset", vec_count, 16'hFFFE);
    send_vec(50'h0, 1'b0, K_ZERO);
    finish_vec(50'h0, -1);
    check("vec_count_ffff", vec_count, 16'hFFFF);
    v = 50'h3_FFFF_FFFF_FFFF;
    send_vec(v, 1'b0, team_dut(v));
    finish_vec(v, -1);
    check("vec_count_saturated", vec_count, 16'hFFFF);

    repeat (3) tick();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/vec_scan_port.md
VEC_SCAN_PORT -- requirements
Module: vec_scan_port

Interface
REQ-001 Parameter IN_W, default 50, stimulus vector width in bits.
REQ-002 Parameter OUT_W, default 30, response vector width in bits.
REQ-003 Parameter SETTLE, default 2, cycles dut_in is held stable before capture; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 si  input  1  serial stimulus bit, MSB first.
REQ-007 si_valid  input  1  si carries a valid bit this cycle.
REQ-008 si_ready  output  1  block accepts a stimulus bit this cycle.
REQ-009 dut_in  output  IN_W  parallel stimulus to the device under test.
REQ-010 dut_out  input  OUT_W  parallel response from the device under test (combinational).
REQ-011 so  output  1  serial response bit, MSB first.
REQ-012 so_valid  output  1  so carries a valid bit this cycle.
REQ-013 so_ready  input  1  consumer accepts so this cycle.
REQ-014 busy  output  1  high in every state except IDLE.
REQ-015 vec_count  output  16  number of completed vectors, saturating at 16'hFFFF.

Function
REQ-016 The block SHALL implement FSM states IDLE, SHIFT_IN, APPLY, CAPTURE, SHIFT_OUT.
REQ-017 IDLE: si_ready=1; a si_valid&si_ready beat SHALL load that bit as bit IN_W-1 of the shift register and move to SHIFT_IN with bit counter = 1.
REQ-018 SHIFT_IN: si_ready=1; each beat shifts in the next lower bit; si_valid low stalls with no state change.
REQ-019 On the beat completing bit 0 (IN_W beats total), the FSM SHALL go to APPLY and copy the shift register to dut_in on that same edge.
REQ-020 APPLY SHALL last exactly SETTLE cycles with dut_in constant and si_ready=0, then go to CAPTURE.
REQ-021 CAPTURE SHALL last one cycle, latch dut_out into the response register, and go to SHIFT_OUT.
REQ-022 SHIFT_OUT: so_valid=1 and so = current response MSB; each so_valid&so_ready beat shifts left by one; so_ready low holds so stable.
REQ-023 After the OUT_W-th beat the FSM SHALL return to IDLE and increment vec_count unless it is already 16'hFFFF.
REQ-024 Latency from last stimulus beat to so_valid rising SHALL be SETTLE+1 cycles; rising so_valid is registered.
REQ-025 dut_in SHALL hold its last applied value through SHIFT_OUT and IDLE until the next APPLY.
REQ-026 si_ready SHALL be 0 in APPLY, CAPTURE and SHIFT_OUT; si_valid is ignored there (no buffering).
REQ-027 so_valid SHALL be 0 outside SHIFT_OUT; so SHALL be 0 whenever so_valid is 0.
REQ-028 Counter widths SHALL be the minimum holding IN_W, OUT_W and SETTLE; no wrap occurs inside a vector.

Reset
REQ-029 rst_n low SHALL immediately force IDLE and clear dut_in, both shift registers, all counters, vec_count, so, so_valid and busy; si_ready=1 after reset.
REQ-030 Reset asserted mid-vector (any state) SHALL discard the partial vector without incrementing vec_count; deassertion takes effect at the next clk edge.

Structure
REQ-031 The state enumeration and default widths (50, 30) SHALL live in the shared package vec_scan_pkg.
REQ-032 One sub-module is natural: vec_shreg, a parameterised parallel-load/serial shift register with enable, instantiated for stimulus (serial-in) and response (serial-out).
REQ-033 The device under test SHALL be instantiated outside this block; only dut_in/dut_out connect it.

Verification
REQ-034 Reset then 50 beats of 0 with team dut connected -> after SETTLE+1 cycles 30 so beats read 100101010101001011101001011000; vec_count=1.
REQ-035 Stimulus with bit 3=1, bit 2=1, rest 0 -> response bit 29=0, bit 3=0; bits 28:4 equal 0010101010100101110100101.
REQ-036 si_valid toggled every other cycle during shift-in -> dut_in equals sent vector, APPLY entry delayed by stalls only.
REQ-037 so_ready held low for 5 cycles mid-unload -> so/so_valid stable, no bits lost or duplicated.
REQ-038 rst_n pulsed low after 20 stimulus beats -> all outputs zero, vec_count unchanged at 0, next full vector processes normally.
REQ-039 vec_count forced near 16'hFFFF (2 vectors from 16'hFFFE) -> saturates at 16'hFFFF.
